uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the full-featured UART receiver. Captures each received word plus its parity and frame error flags on the receiver's done tick and queues them in a first-word-fall-through FIFO. The host side pops entries with a single-cycle read strobe. Status outputs: empty, full, occupancy count, threshold flag, and a sticky overrun flag.

Parameters:
DATA_W, 8, data word width; matches receiver o_data.
ADDR_W, 4, FIFO address width; depth = 2**ADDR_W entries.

Ports:
i_clk  input  1  system clock, all logic on rising edge.
i_reset_n  input  1  asynchronous, active-low reset.
i_rx_done_tick  input  1  one-cycle strobe from receiver: word complete, push request.
i_rx_data  input  DATA_W  received word, valid when i_rx_done_tick=1.
i_par_err  input  1  receiver parity error, valid with i_rx_done_tick.
i_frm_err  input  1  receiver frame error, valid with i_rx_done_tick.
i_rd  input  1  pop strobe; removes head entry if not empty.
i_ovr_clr  input  1  clears sticky overrun flag.
i_thresh  input  ADDR_W+1  occupancy threshold for o_level.
o_data  output  DATA_W  head entry data (FWFT); 0 when empty.
o_par_err  output  1  head entry parity flag; 0 when empty.
o_frm_err  output  1  head entry frame flag; 0 when empty.
o_empty  output  1  FIFO holds no entries.
o_full  output  1  FIFO holds 2**ADDR_W entries.
o_count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W.
o_level  output  1  1 when o_count >= i_thresh (combinational from registered count).
o_overrun  output  1  sticky: a push was dropped because FIFO was full.

Behaviour:
- Storage: 2**ADDR_W entries of {frm_err, par_err, data} (DATA_W+2 bits). Array not reset.
- Registers: wr_ptr, rd_ptr (ADDR_W bits, natural wrap 2**ADDR_W-1 -> 0), count (ADDR_W+1 bits), overrun.
- Reset (i_reset_n=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, overrun=0. Resulting outputs: o_empty=1, o_full=0, o_count=0, o_overrun=0, o_data=0, o_par_err=0, o_frm_err=0. o_level = (i_thresh==0). Reset mid-operation discards all queued entries.
- push = i_rx_done_tick. pop = i_rd & ~o_empty. i_rd while empty is ignored, with no error flag.
- Push accepted when ~o_full, or when o_full and pop in the same cycle. Entry written at mem[wr_ptr]; wr_ptr+1.
- Pop: rd_ptr+1. Head is read combinationally: o_data/flags = mem[rd_ptr] gated by ~o_empty.
- Count update:
  - push only: +1
  - pop only: -1
  - both, or neither: unchanged
- o_empty = (count==0). o_full = (count==2**ADDR_W). Both derive from registered count.
- Latency: a word pushed in cycle N appears on o_data and o_empty=0 in cycle N+1. A pop in cycle N presents the next entry in cycle N+1.
- Simultaneous push+pop when empty: pop ignored, push accepted, count becomes 1.
- Simultaneous push+pop when full: both occur, count stays 2**ADDR_W, no overrun.
- Overrun: push while full and no pop drops the incoming word. Stored contents are untouched and overrun is set to 1 next cycle.
- i_ovr_clr clears overrun next cycle. If a new overrun occurs in the same cycle as i_ovr_clr, set wins.
- Error flags are stored per entry and do not affect acceptance. Words with par/frm error are queued like any other.

Test Plan:
- Reset, ADDR_W=2: assert i_reset_n=0 mid-stream -> o_empty=1, o_count=0, o_data=0, o_overrun=0 immediately (asynchronous), holding until release.
- Push 0x41, 0x42, 0x43 with no reads, then pop 3 times -> o_data sequence 0x41, 0x42, 0x43, then o_empty=1. o_count goes 1, 2, 3, then 2, 1, 0.
- Push 0x55 with i_par_err=1, then 0x66 with i_frm_err=1 -> head shows 0x55/par=1/frm=0; after pop, 0x66/par=0/frm=1.
- Fill 4 entries (0x10..0x13), push 0x99 -> o_full=1, o_overrun=1 next cycle, 0x99 absent; pops yield 0x10..0x13. Then i_ovr_clr -> o_overrun=0.
- When full, push 0xAA with i_rd=1 in the same cycle -> o_count stays 4, o_overrun=0, 0xAA is last out. When empty, push+i_rd -> o_count=1, o_data=pushed word.
- Wrap and threshold: i_thresh=3, 10 push/pop cycles crossing pointer wrap -> FIFO order preserved, o_level=1 exactly when o_count>=3.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer behind the UART receiver: queues each word with its
// parity/frame flags and reports occupancy, threshold and sticky overrun status.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_rx_done_tick,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_par_err,
    input  logic              i_frm_err,
    input  logic              i_rd,
    input  logic              i_ovr_clr,
    input  logic [ADDR_W:0]   i_thresh,
    output logic [DATA_W-1:0] o_data,
    output logic              o_par_err,
    output logic              o_frm_err,
    output logic              o_empty,
    output logic              o_full,
    output logic [ADDR_W:0]   o_count,
    output logic              o_level,
    output logic              o_overrun
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    // Entry layout: {frm_err, par_err, data}
    logic [DATA_W+1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              overrun;

    logic              push;
    logic              pop;
    logic              wr_en;
    logic              drop;
    logic [DATA_W+1:0] head;

    assign o_empty = (count == '0);
    assign o_full  = (count == FULL_COUNT);

    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign push  = i_rx_done_tick;
    assign pop   = i_rd & ~o_empty;
    assign wr_en = push & (~o_full | pop);
    assign drop  = push & o_full & ~pop;

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {i_frm_err, i_par_err, i_rx_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new drop takes priority over a clear in the same cycle.
            if (drop) begin
                overrun <= 1'b1;
            end else if (i_ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign head      = mem[rd_ptr];
    assign o_data    = o_empty ? '0 : head[DATA_W-1:0];
    assign o_par_err = o_empty ? 1'b0 : head[DATA_W];
    assign o_frm_err = o_empty ? 1'b0 : head[DATA_W+1];
    assign o_count   = count;
    assign o_level   = (count >= i_thresh);
    assign o_overrun = overrun;

endmodule
